// File: rtl/dac_frame_serializer.sv
// Pulls one FIFO sample per frame and shifts {CTRL_WORD, sample, zero pad} MSB-first to a serial DAC.
// Define DAC_MIDSCALE_ON_UNDERRUN_EN to send midscale instead of repeating the last sample on underrun.
module dac_frame_serializer #(
    parameter int unsigned CLKS_PER_FRAME = 1200,
    parameter int unsigned CLKS_PER_BCLK  = 12,
    parameter int unsigned DATA_LENGTH    = 24,
    parameter int unsigned SAMPLE_WIDTH   = 8,
    parameter int unsigned CTRL_BITS      = 8,
    parameter int unsigned CTRL_WORD      = 0,
    parameter int unsigned UCNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    empty,
    output logic                    read,
    output logic                    sdata,
    output logic                    bclk,
    output logic                    nsync,
    output logic                    sample_tick,
    output logic                    underrun,
    output logic [UCNT_WIDTH-1:0]   underrun_count
);

    localparam int unsigned CntW = $clog2(CLKS_PER_FRAME);
    localparam int unsigned PhW  = $clog2(CLKS_PER_BCLK);
    localparam int unsigned BitW = $clog2(DATA_LENGTH);

    localparam logic [CntW-1:0]      LastCnt  = CntW'(CLKS_PER_FRAME - 1);
    localparam logic [PhW-1:0]       LastPh   = PhW'(CLKS_PER_BCLK - 1);
    localparam logic [PhW-1:0]       HalfBclk = PhW'(CLKS_PER_BCLK / 2);
    localparam logic [BitW-1:0]      LastBit  = BitW'(DATA_LENGTH - 1);
    localparam logic [CTRL_BITS-1:0] CtrlVal  = CTRL_BITS'(CTRL_WORD);
`ifdef DAC_MIDSCALE_ON_UNDERRUN_EN
    localparam logic [SAMPLE_WIDTH-1:0] Midscale = {1'b1, {(SAMPLE_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StLoad,
        StShift
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [PhW-1:0]          ph_q, ph_d;
    logic [BitW-1:0]         bit_q, bit_d;
    logic [DATA_LENGTH-1:0]  sr_q, sr_d;
    logic [SAMPLE_WIDTH-1:0] held_q, held_d;
    logic                    rd_q, rd_d;
    logic [UCNT_WIDTH-1:0]   ucnt_q, ucnt_d;
    logic [DATA_LENGTH-1:0]  word;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        sr_d        = sr_q;
        held_d      = held_q;
        rd_d        = 1'b0;
        ucnt_d      = ucnt_q;
        word        = '0;
        read        = 1'b0;
        sample_tick = 1'b0;
        underrun    = 1'b0;
        nsync       = 1'b1;
        bclk        = 1'b1;
        sdata       = 1'b0;

        // Frame counter free-runs while enabled or a frame is in flight; parks at 0 otherwise.
        if (state_q == StIdle && !enable) begin
            cnt_d = '0;
        end else if (cnt_q == LastCnt) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (enable && cnt_q == '0) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                sample_tick = 1'b1;
                if (!empty) begin
                    read = 1'b1;
                    rd_d = 1'b1;
                end else begin
                    underrun = 1'b1;
                    if (ucnt_q != '1) begin
                        ucnt_d = ucnt_q + UCNT_WIDTH'(1);
                    end
                end
                state_d = StLoad;
            end
            StLoad: begin
                // FIFO data is valid now, one cycle after the pop.
                if (rd_q) begin
                    held_d = sample;
                end else begin
`ifdef DAC_MIDSCALE_ON_UNDERRUN_EN
                    held_d = Midscale;
`else
                    held_d = held_q;
`endif
                end
                word[DATA_LENGTH-1 -: CTRL_BITS]                = CtrlVal;
                word[DATA_LENGTH-CTRL_BITS-1 -: SAMPLE_WIDTH]   = held_d;
                sr_d    = word;
                ph_d    = '0;
                bit_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                nsync = 1'b0;
                sdata = sr_q[DATA_LENGTH-1];
                bclk  = (ph_q < HalfBclk);
                if (ph_q == LastPh) begin
                    ph_d = '0;
                    sr_d = sr_q << 1;
                    if (bit_q == LastBit) begin
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    ph_d = ph_q + PhW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            held_q  <= '0;
            rd_q    <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            held_q  <= held_d;
            rd_q    <= rd_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Bench for dac_frame_serializer: FIFO model, serial capture monitor and a queue of expected frame words.
`timescale 1ns/1ps
module tb_dac_frame_serializer;

    localparam int unsigned SW    = 8;
    localparam int unsigned DL    = 24;
    localparam int unsigned UW    = 2;
    localparam int unsigned FRAME = 1200;
    localparam int unsigned BCLK  = 12;

`ifdef DAC_MIDSCALE_ON_UNDERRUN_EN
    localparam logic [DL-1:0] UrWordA = 24'h008000;
    localparam logic [DL-1:0] UrWordB = 24'h008000;
`else
    localparam logic [DL-1:0] UrWordA = 24'h007F00;
    localparam logic [DL-1:0] UrWordB = 24'h003C00;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          empty = 1'b1;
    logic [SW-1:0] sample = '0;
    logic          read, sdata, bclk, nsync, sample_tick, underrun;
    logic [UW-1:0] underrun_count;

    always #5 clk = ~clk;

    dac_frame_serializer #(
        .CLKS_PER_FRAME(FRAME),
        .CLKS_PER_BCLK (BCLK),
        .DATA_LENGTH   (DL),
        .SAMPLE_WIDTH  (SW),
        .CTRL_BITS     (8),
        .CTRL_WORD     (0),
        .UCNT_WIDTH    (UW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sample        (sample),
        .empty         (empty),
        .read          (read),
        .sdata         (sdata),
        .bclk          (bclk),
        .nsync         (nsync),
        .sample_tick   (sample_tick),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: data appears on sample one cycle after read.
    logic [SW-1:0] fifo[$];
    always @(posedge clk) begin
        if (read && fifo.size() > 0) sample <= fifo.pop_front();
        empty <= (fifo.size() == 0);
    end

    // Serial capture monitor and scoreboard.
    logic [DL-1:0] exp_q[$];
    logic [DL-1:0] cap = '0;
    int  nb = 0, low_cnt = 0, cyc = 0, tick_cyc = 0, first_fall = 0, last_fall = 0;
    int  n_reads = 0, n_ticks = 0;
    bit  per_ok = 1'b1, prev_bclk = 1'b1, prev_nsync = 1'b1, bad_read = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            cap = '0; nb = 0; low_cnt = 0; per_ok = 1'b1;
            prev_bclk = 1'b1; prev_nsync = 1'b1;
            exp_q.delete();
        end else begin
            if (read) n_reads++;
            if (read && empty) bad_read = 1'b1;
            if (sample_tick) begin
                n_ticks++;
                tick_cyc = cyc;
            end
            if (!nsync) begin
                low_cnt++;
                if (prev_bclk && !bclk) begin
                    if (nb == 0) first_fall = cyc;
                    else if (cyc - last_fall != BCLK) per_ok = 1'b0;
                    last_fall = cyc;
                    cap = {cap[DL-2:0], sdata};
                    nb++;
                end
            end
            if (!prev_nsync && nsync) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got 0x%0h, expected no frame", cap);
                end else begin
                    check("frame_word", 32'(cap), 32'(exp_q.pop_front()));
                    check("frame_bits", nb, DL);
                    check("nsync_low_cycles", low_cnt, DL * BCLK);
                    check("first_fall_latency", first_fall - tick_cyc, 2 + BCLK / 2);
                    check("bclk_period", 32'(per_ok), 1);
                end
                cap = '0; nb = 0; low_cnt = 0; per_ok = 1'b1;
            end
            prev_bclk  = bclk;
            prev_nsync = nsync;
        end
    end

    task automatic wait_tick(input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (sample_tick) ok = 1'b1;
        end
        check(name, 32'(ok), 1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    typedef struct {
        bit            push;
        logic [SW-1:0] data;
        logic [DL-1:0] word;
        bit            ur;
        logic [UW-1:0] cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit  ok;
        time t_prev, t_now;
        vecs[0] = '{1'b1, 8'hA5, 24'h00A500, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 8'h01, 24'h000100, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 8'h02, 24'h000200, 1'b0, 2'd0};
        vecs[3] = '{1'b1, 8'h03, 24'h000300, 1'b0, 2'd0};
        vecs[4] = '{1'b1, 8'h7F, 24'h007F00, 1'b0, 2'd0};
        vecs[5] = '{1'b0, 8'h00, UrWordA,    1'b1, 2'd1};
        vecs[6] = '{1'b0, 8'h00, UrWordA,    1'b1, 2'd2};
        vecs[7] = '{1'b0, 8'h00, UrWordA,    1'b1, 2'd3};
        vecs[8] = '{1'b0, 8'h00, UrWordA,    1'b1, 2'd3};
        vecs[9] = '{1'b0, 8'h00, UrWordA,    1'b1, 2'd3};
        t_prev = 0;

        // Reset state, then a continuous run of frames ending in five underruns.
        rst = 1'b1;
        enable = 1'b1;
        foreach (vecs[i]) if (vecs[i].push) fifo.push_back(vecs[i].data);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read", 32'(read), 0);
        check("rst_sdata", 32'(sdata), 0);
        check("rst_bclk", 32'(bclk), 1);
        check("rst_nsync", 32'(nsync), 1);
        check("rst_tick", 32'(sample_tick), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_ucount", 32'(underrun_count), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            wait_tick(FRAME + 100, "tick_seen", ok);
            if (!ok) break;
            t_now = $time;
            if (i > 0) check("tick_period", int'((t_now - t_prev) / 10), FRAME);
            t_prev = t_now;
            check("read_at_tick", 32'(read), 32'(!vecs[i].ur));
            check("underrun_at_tick", 32'(underrun), 32'(vecs[i].ur));
            exp_q.push_back(vecs[i].word);
            @(negedge clk);
            check("read_pulse_end", 32'(read), 0);
            check("underrun_pulse_end", 32'(underrun), 0);
            check("nsync_T1", 32'(nsync), 1);
            check("ucount", 32'(underrun_count), 32'(vecs[i].cnt));
            @(negedge clk);
            check("nsync_T2", 32'(nsync), 0);
        end
        wait_drain("drain_run");
        check("read_total", n_reads, 5);

        // enable dropped at bit 10: frame completes, then no ticks or reads.
        @(posedge clk);
        #1 rst = 1'b1;
        fifo.push_back(8'h3C);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_tick(5, "tick_after_rst", ok);
        check("read_3c", 32'(read), 1);
        exp_q.push_back(24'h003C00);
        repeat (2 + 10 * BCLK) @(negedge clk);
        enable = 1'b0;
        wait_drain("drain_disable");
        begin
            int r0, t0;
            r0 = n_reads;
            t0 = n_ticks;
            repeat (1500) @(negedge clk);
            check("disabled_reads", n_reads - r0, 0);
            check("disabled_ticks", n_ticks - t0, 0);
            check("disabled_nsync", 32'(nsync), 1);
        end
        enable = 1'b1;
        wait_tick(4, "tick_reenable", ok);
        check("reenable_read", 32'(read), 0);
        check("reenable_underrun", 32'(underrun), 1);
        exp_q.push_back(UrWordB);
        @(negedge clk);
        check("reenable_ucount", 32'(underrun_count), 1);

        // Reset at bit 5 aborts the frame; the next frame starts fresh with a read.
        repeat (2 + 5 * BCLK + 2) @(negedge clk);
        fifo.push_back(8'h66);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_nsync", 32'(nsync), 1);
        check("abort_bclk", 32'(bclk), 1);
        check("abort_sdata", 32'(sdata), 0);
        check("abort_ucount", 32'(underrun_count), 0);
        check("abort_read", 32'(read), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_tick(4, "tick_post_abort", ok);
        check("post_abort_read", 32'(read), 1);
        check("post_abort_underrun", 32'(underrun), 0);
        exp_q.push_back(24'h006600);
        wait_drain("drain_post_abort");
        check("read_while_empty", 32'(bad_read), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
